// File: rtl/game_turn_ctrl.sv
// game_turn_ctrl: two-player dice race turn sequencer.
// Rolls a dice, publishes the active player's target x, waits for the animation.
module game_turn_ctrl #(
  parameter int START_X        = 20,
  parameter int FLAG_X         = 620,
  parameter int STEP_PX        = 40,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll_btn,
  input  logic       new_game,
  input  logic [2:0] dice_override,
  input  logic       turn_done,
  output logic [9:0] player1_pos_x,
  output logic [9:0] player2_pos_x,
  output logic       pos_valid,
  output logic       active_player,
  output logic [2:0] dice_value,
  output logic       busy,
  output logic       winner_valid,
  output logic       winner_id,
  output logic       timeout_flag
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] TMO_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  localparam logic [9:0]  START10 = 10'(START_X);
  localparam logic [9:0]  FLAG10  = 10'(FLAG_X);
  localparam logic [10:0] FLAG11  = 11'(FLAG_X);
  localparam logic [10:0] STEP11  = 11'(STEP_PX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROLL,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_OVER
  } state_t;

  state_t state;
  state_t state_nx;

  logic          roll_prev;
  logic          roll_edge;
  logic [7:0]    lfsr;
  logic          lfsr_fb;
  logic [2:0]    rnd_dice;
  logic          ovr_ok;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          ng_ok;
  logic [9:0]    act_pos;
  logic [10:0]   sum11;
  logic [9:0]    target;
  logic          at_flag;

  assign roll_edge = roll_btn & ~roll_prev;

  assign lfsr_fb = lfsr[7] ^ lfsr[5]
                 ^ lfsr[4] ^ lfsr[3];

  assign rnd_dice = 3'(lfsr % 8'd6) + 3'd1;

  assign ovr_ok = (dice_override != 3'd0)
               && (dice_override != 3'd7);

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  assign ng_ok = new_game
              && ((state == S_IDLE)
               || (state == S_OVER));

  assign act_pos = active_player
                 ? player2_pos_x
                 : player1_pos_x;

  // Widened add so a near-flag position cannot wrap before the clamp.
  assign sum11 = {1'b0, act_pos}
               + 11'(dice_value) * STEP11;

  assign target = (sum11 > FLAG11)
                ? FLAG10
                : sum11[9:0];

  assign at_flag = (act_pos == FLAG10);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; new_game outranks a roll request in IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (new_game) begin
          state_nx = S_IDLE;
        end else if (roll_edge) begin
          state_nx = S_ROLL;
        end
      end
      S_ROLL: begin
        state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (turn_done || tmo_hit) begin
          state_nx = S_NEXT;
        end
      end
      S_NEXT: begin
        state_nx = at_flag ? S_OVER : S_IDLE;
      end
      S_OVER: begin
        if (new_game) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    pos_valid    = (state == S_ISSUE);
    busy         = (state != S_IDLE)
                && (state != S_OVER);
    winner_valid = (state == S_OVER);
  end

  // Free-running dice source; taps keep it out of the all-zero lockup.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end

  // Previous roll_btn sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      roll_prev <= 1'b0;
    end else begin
      roll_prev <= roll_btn;
    end
  end

  // Wait counter; held at zero outside WAIT so every wait starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state != S_WAIT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  // Dice latch on the accepted roll request.
  always_ff @(posedge clk) begin
    if (rst) begin
      dice_value <= 3'd0;
    end else if (ng_ok) begin
      dice_value <= 3'd0;
    end else if ((state == S_IDLE) && roll_edge) begin
      dice_value <= ovr_ok ? dice_override : rnd_dice;
    end
  end

  // Player targets; only the active player's register is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      player1_pos_x <= START10;
      player2_pos_x <= START10;
    end else if (ng_ok) begin
      player1_pos_x <= START10;
      player2_pos_x <= START10;
    end else if (state == S_ROLL) begin
      if (active_player) begin
        player2_pos_x <= target;
      end else begin
        player1_pos_x <= target;
      end
    end
  end

  // Turn ownership and the winner record at the end of a turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_player <= 1'b0;
      winner_id     <= 1'b0;
    end else if (ng_ok) begin
      active_player <= 1'b0;
    end else if (state == S_NEXT) begin
      if (at_flag) begin
        winner_id <= active_player;
      end else begin
        active_player <= ~active_player;
      end
    end
  end

  // Sticky timeout; a turn_done in the expiring cycle still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_flag <= 1'b0;
    end else if (ng_ok) begin
      timeout_flag <= 1'b0;
    end else if ((state == S_WAIT)
              && !turn_done && tmo_hit) begin
      timeout_flag <= 1'b1;
    end
  end

endmodule

// File: doc/game_turn_ctrl.md
GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

Interface
REQ-001 SHALL have parameter START_X, default 20, start x coordinate of both players.
REQ-002 SHALL have parameter FLAG_X, default 620, goal x coordinate; targets clamp to it.
REQ-003 SHALL have parameter STEP_PX, default 40, pixels moved per dice pip.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1048575, maximum wait for turn_done.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port roll_btn  input  1  debounced roll request level; a rising edge requests a roll.
REQ-008 SHALL have port new_game  input  1  level; restarts the game.
REQ-009 SHALL have port dice_override  input  3  1..6 replaces the random dice value; 0 or 7 selects random.
REQ-010 SHALL have port turn_done  input  1  1-cycle pulse from the player animation block.
REQ-011 SHALL have port player1_pos_x  output  10  Player 1 target x.
REQ-012 SHALL have port player2_pos_x  output  10  Player 2 target x.
REQ-013 SHALL have port pos_valid  output  1  1-cycle pulse; new target published.
REQ-014 SHALL have port active_player  output  1  0=Player1, 1=Player2.
REQ-015 SHALL have port dice_value  output  3  last rolled value 1..6; 0 means no roll yet.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE and GAME_OVER.
REQ-017 SHALL have port winner_valid  output  1  high in GAME_OVER.
REQ-018 SHALL have port winner_id  output  1  player that reached FLAG_X; valid when winner_valid is high.
REQ-019 SHALL have port timeout_flag  output  1  sticky; set when a turn_done wait expires.

Function
REQ-020 SHALL run an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that advances every cycle and never holds 0.
REQ-021 SHALL derive the random dice value as (lfsr mod 6)+1.
REQ-022 SHALL detect a roll_btn rising edge with a registered previous sample.
REQ-023 SHALL have FSM states IDLE, ROLL, ISSUE, WAIT_DONE, NEXT, GAME_OVER.
REQ-024 IDLE: a roll_btn rising edge SHALL go to ROLL; in the same cycle dice_value SHALL latch the override value if it is 1..6, else the random value.
REQ-025 ROLL (1 cycle): SHALL compute target = active position + dice*STEP_PX using 11-bit arithmetic, clamp to FLAG_X, and load the target into the active player's pos_x register.
REQ-026 ISSUE (1 cycle): SHALL assert pos_valid for exactly one cycle, then go to WAIT_DONE.
REQ-027 The inactive player's pos_x SHALL never change during a turn.
REQ-028 WAIT_DONE: turn_done SHALL go to NEXT.
REQ-029 WAIT_DONE: if TIMEOUT_CYCLES elapse without turn_done, the FSM SHALL set timeout_flag and go to NEXT.
REQ-030 WAIT_DONE: the timeout counter SHALL clear on entry to WAIT_DONE.
REQ-031 NEXT (1 cycle): if the active player's pos_x equals FLAG_X, the FSM SHALL set winner_id = active_player and go to GAME_OVER.
REQ-032 NEXT: otherwise the FSM SHALL toggle active_player and go to IDLE.
REQ-033 GAME_OVER SHALL ignore roll_btn and turn_done.
REQ-034 new_game high in IDLE or GAME_OVER SHALL, next cycle: set both pos_x to START_X, active_player 0, dice_value 0, winner_valid 0, timeout_flag 0; state IDLE; no pos_valid.
REQ-035 new_game in any other state SHALL be ignored.
REQ-036 roll_btn edges outside IDLE SHALL be ignored and not queued.
REQ-037 turn_done outside WAIT_DONE SHALL be ignored.
REQ-038 pos_valid SHALL be low for at least 2 cycles between pulses, so a rising-edge detector at the receiver sees every pulse.
REQ-039 A roll from a pos_x already equal to FLAG_X SHALL keep it clamped at FLAG_X.

Reset
REQ-040 rst SHALL override all other inputs.
REQ-041 rst SHALL set: state IDLE; player1_pos_x and player2_pos_x START_X; active_player 0; dice_value 0; pos_valid 0; busy 0; winner_valid 0; winner_id 0; timeout_flag 0; lfsr 8'hA5; timeout counter 0.
REQ-042 rst asserted mid-turn (any state) SHALL abandon the turn, with outputs at reset values on the next cycle.

Verification
REQ-043 SHALL verify: override 3, roll from reset -> player1_pos_x 140; one pos_valid pulse 2 cycles after the edge; active_player 0 until turn_done; then active_player 1.
REQ-044 SHALL verify: P1 at 580, override 2 -> player1_pos_x 620; turn_done -> winner_valid 1, winner_id 0; later roll_btn edge -> no pos_valid.
REQ-045 SHALL verify: TIMEOUT_CYCLES=16, no turn_done -> timeout_flag 1 after 16 WAIT_DONE cycles; turn passes to Player 2.
REQ-046 SHALL verify: roll_btn toggled during WAIT_DONE -> no second pos_valid; new_game in WAIT_DONE -> ignored.
REQ-047 SHALL verify: rst in WAIT_DONE with P2 at 260 -> both pos_x 20, active_player 0, busy 0 next cycle.
REQ-048 SHALL verify: override 0, 1000 rolls -> dice_value always 1..6 and every value occurs; lfsr never 0.
